fast_mem_mp: RTL and testbench

- Parametrised multi-port fast memory (accumulator store) on the membus.
- Serves NPORTS processor ports with round-robin arbitration instead of fixed jumper selection.
- Supports configurable depth and word width, read/write/read-modify-write cycles, a write-restart timeout, single-step stop, and an Avalon-style maintenance slave.
- Sits beside the core memory controllers on each processor's membus.

---
 rtl/fast_mem_mp.sv | 119 +++++++++++
 tb/tb_fast_mem_mp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fast_mem_mp.sv
// fast_mem_mp: multi-port membus fast memory with round-robin grant, RMW cycles,
// write-restart timeout, single-step stop and an Avalon-style maintenance slave.
module fast_mem_mp #(
  parameter int                NPORTS  = 4,
  parameter int                AW      = 4,
  parameter int                DW      = 36,
  parameter logic [3:0]        MEMSEL  = 4'b0000,
  parameter logic [NPORTS-1:0] PORT_EN = {NPORTS{1'b1}},
  parameter int                TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sw_single_step,
  input  logic                 sw_restart,
  input  logic [NPORTS-1:0]    rq_cyc,
  input  logic [NPORTS-1:0]    rd_rq,
  input  logic [NPORTS-1:0]    wr_rq,
  input  logic [NPORTS-1:0]    wr_rs,
  input  logic [NPORTS-1:0]    fmc_select,
  input  logic [4*NPORTS-1:0]  sel,
  input  logic [AW*NPORTS-1:0] ma,
  input  logic [DW*NPORTS-1:0] mb_in,
  output logic [NPORTS-1:0]    addr_ack,
  output logic [NPORTS-1:0]    rd_rs,
  output logic [DW*NPORTS-1:0] mb_out,
  output logic                 busy,
  output logic                 stopped,
  output logic                 timeout_err,
  input  logic [AW-1:0]        s_address,
  input  logic                 s_read,
  input  logic                 s_write,
  input  logic [DW-1:0]        s_writedata,
  output logic [DW-1:0]        s_readdata,
  output logic                 s_waitrequest
);
  localparam int GW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  typedef enum logic [2:0] {IDLE, ACK, RD, WAIT_WR, DONE} state_t;
  state_t            r_state, w_next;
  logic [GW-1:0]     r_g, r_last, w_pick;
  logic [AW-1:0]     r_addr;
  logic              r_rd, r_wr, r_stopped, r_restart_q;
  logic [7:0]        r_cnt;
  logic [DW-1:0]     r_mem [2**AW];
  logic [NPORTS-1:0] w_elig;
  logic              w_any, w_av, w_wr_go, w_to, w_restart;
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NPORTS; i++)
      w_elig[i] = PORT_EN[i] & rq_cyc[i] & fmc_select[i] & (sel[4*i +: 4] == MEMSEL) & ~r_stopped;
  end
  // Scan downward so the nearest eligible port after last_grant is the final assignment
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    for (int k = NPORTS; k >= 1; k--)
      if (w_elig[(int'(r_last) + k) % NPORTS]) begin
        w_pick = GW'((int'(r_last) + k) % NPORTS);
        w_any  = 1'b1;
      end
  end
  assign w_av      = s_read | s_write;
  assign w_restart = sw_restart & ~r_restart_q;
  assign w_wr_go   = (r_state == WAIT_WR) & wr_rs[r_g];
  assign w_to      = (r_state == WAIT_WR) & ~wr_rs[r_g] & (r_cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (!w_av && w_any) ? ACK : IDLE;
      ACK:     w_next = r_rd ? RD : r_wr ? WAIT_WR : DONE;
      RD:      w_next = wr_rq[r_g] ? WAIT_WR : DONE;
      WAIT_WR: w_next = (w_wr_go || w_to) ? DONE : WAIT_WR;
      DONE:    w_next = rq_cyc[r_g] ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_stopped   <= 1'b0;
      r_last      <= GW'(NPORTS - 1);
      r_cnt       <= 8'd0;
      r_g         <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_restart_q <= 1'b0;
    end else begin
      r_restart_q <= sw_restart;
      r_cnt       <= (r_state == WAIT_WR) ? r_cnt + 8'd1 : 8'd0;
      if (r_state == IDLE && w_next == ACK) begin
        r_g    <= w_pick;
        r_addr <= ma[w_pick*AW +: AW];
        r_rd   <= rd_rq[w_pick];
        r_wr   <= wr_rq[w_pick];
      end
      if (r_state == DONE) r_last <= r_g;
      if (w_next == DONE && r_state != DONE && sw_single_step) r_stopped <= 1'b1;
      else if (w_restart) r_stopped <= 1'b0;
    end
  // Storage is deliberately not reset; writes are suppressed while reset is held
  always_ff @(posedge clk)
    if (reset_n && r_state == IDLE && s_write) r_mem[s_address] <= s_writedata;
    else if (reset_n && w_wr_go) r_mem[r_addr] <= mb_in[r_g*DW +: DW];
  always_comb begin
    addr_ack       = '0;
    rd_rs          = '0;
    mb_out         = '0;
    addr_ack[r_g]  = (r_state == ACK);
    rd_rs[r_g]     = (r_state == RD);
    if (r_state == RD) mb_out[r_g*DW +: DW] = r_mem[r_addr];
    busy          = (r_state != IDLE);
    s_waitrequest = (r_state != IDLE);
    timeout_err   = w_to;
    stopped       = r_stopped;
  end
  assign s_readdata = r_mem[s_address];
endmodule

// File: tb/tb_fast_mem_mp.sv
// tb_fast_mem_mp: scoreboard bench; stimulus pushes expected membus events, a negedge monitor pops them.
module tb_fast_mem_mp;
  localparam int NP = 4, AW = 4, DW = 36, W = DW*NP;
  logic clk = 0, reset_n = 1, sw_single_step = 0, sw_restart = 0;
  logic [NP-1:0] rq_cyc = '0, rd_rq = '0, wr_rq = '0, wr_rs = '0, fmc_select = '0;
  logic [4*NP-1:0] sel = '0;
  logic [AW*NP-1:0] ma = '0;
  logic [W-1:0] mb_in = '0, mb_out;
  logic [NP-1:0] addr_ack, rd_rs;
  logic busy, stopped, timeout_err, s_waitrequest;
  logic [AW-1:0] s_address = '0;
  logic s_read = 0, s_write = 0;
  logic [DW-1:0] s_writedata = '0, s_readdata;
  fast_mem_mp dut (
    .clk(clk), .reset_n(reset_n), .sw_single_step(sw_single_step), .sw_restart(sw_restart),
    .rq_cyc(rq_cyc), .rd_rq(rd_rq), .wr_rq(wr_rq), .wr_rs(wr_rs), .fmc_select(fmc_select),
    .sel(sel), .ma(ma), .mb_in(mb_in), .addr_ack(addr_ack), .rd_rs(rd_rs), .mb_out(mb_out),
    .busy(busy), .stopped(stopped), .timeout_err(timeout_err), .s_address(s_address),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest));
  always #5 clk = ~clk;
  typedef struct {int k; int p; logic [DW-1:0] d;} ev_t;
  ev_t q[$];
  logic [DW-1:0] model [16];
  int mlast = NP - 1;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  function automatic int pick(input logic [NP-1:0] m, input int last);
    for (int k = 1; k <= NP; k++) if (m[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction
  task automatic expect_ev(input int k, input int p, input logic [DW-1:0] d);
    q.push_back('{k, p, d});
  endtask
  task automatic pop(input int k, input int p, input logic [DW-1:0] d);
    ev_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event kind=%0d port=%0d got=event want=none", k, p);
    end else begin
      e = q.pop_front();
      chk("ev_kind", k, e.k);
      if (p >= 0) chk("ev_port", p, e.p);
      if (k == 1) begin
        chk("rd_data", d, e.d);
        chk("mb_out_slices", mb_out, {{(DW*(NP-1)){1'b0}}, e.d} << (DW*e.p));
      end
    end
  endtask
  always @(negedge clk) if (reset_n) begin
    for (int i = 0; i < NP; i++) begin
      if (addr_ack[i]) pop(0, i, '0);
      if (rd_rs[i]) pop(1, i, mb_out[DW*i +: DW]);
    end
    if (timeout_err) pop(2, -1, '0);
    if (rd_rs == '0) chk("mb_out_idle", mb_out, '0);
  end
  task automatic av_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_address = a; s_writedata = d; s_write = 1;
    @(posedge clk); #1;
    s_write = 0; model[a] = d;
  endtask
  task automatic av_read(input logic [AW-1:0] a);
    s_address = a; s_read = 1; #1;
    chk("av_rdata", s_readdata, model[a]);
    chk("av_wait", s_waitrequest, 0);
    @(posedge clk); #1;
    s_read = 0;
  endtask
  task automatic xact(input int p, input int a, input bit rd, input bit wr, input bit wrs,
                      input logic [DW-1:0] wd, input int d, input int hold, input bit stall);
    int n;
    expect_ev(0, p, '0);
    if (rd) expect_ev(1, p, model[a]);
    if (wr && !wrs) expect_ev(2, p, '0);
    rq_cyc[p] = 1; fmc_select[p] = 1; sel[4*p +: 4] = 4'h0; ma[AW*p +: AW] = AW'(a);
    rd_rq[p] = rd; wr_rq[p] = wr;
    if (stall) begin
      repeat (4) begin @(posedge clk); #1; end
      chk("stall_busy", busy, 0);
      chk("stall_stopped", stopped, 1);
      av_read(AW'(a));
      sw_single_step = 0; sw_restart = 1;
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!addr_ack[p] && n < 50);
    chk("ack_seen", addr_ack[p], 1);
    if (!stall) chk("ack_latency", n, 1);
    if (wr && wrs) begin
      repeat (d) begin @(posedge clk); #1; end
      mb_in[DW*p +: DW] = wd; wr_rs[p] = 1;
      @(posedge clk); #1;
      wr_rs[p] = 0; model[a] = wd;
    end else if (wr) begin
      n = 0;
      while (!timeout_err && n < 400) begin @(posedge clk); #1; n++; end
      chk("timeout_latency", n, rd ? 256 : 255);
      @(posedge clk); #1;
    end else begin
      repeat (rd ? 2 : 1) begin @(posedge clk); #1; end
    end
    mlast = p;
    chk("done_busy", busy, 1);
    chk("done_stopped", stopped, sw_single_step);
    repeat (hold) begin @(posedge clk); #1; end
    chk("hold_busy", busy, 1);
    rq_cyc[p] = 0; rd_rq[p] = 0; wr_rq[p] = 0; fmc_select[p] = 0; sw_restart = 0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] r;
    logic [AW-1:0] ra [NP];
    int g, n, p, t;
    #2 reset_n = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", addr_ack, 0);
    chk("rst_rd_rs", rd_rs, 0);
    chk("rst_mb_out", mb_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stopped", stopped, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_waitreq", s_waitrequest, 0);
    reset_n = 1;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      r = {$urandom(), $urandom()};
      av_write(AW'(a), r[DW-1:0]);
    end
    // all ports contend; each drops rq_cyc after its DONE and re-requests
    for (int i = 0; i < NP; i++) begin
      ra[i] = AW'($urandom_range(0, 15));
      ma[AW*i +: AW] = ra[i];
    end
    for (int k = 0; k < 2*NP; k++) begin
      p = pick('1, mlast);
      expect_ev(0, p, '0);
      expect_ev(1, p, model[ra[p]]);
      mlast = p;
    end
    rd_rq = '1; fmc_select = '1; sel = '0; rq_cyc = '1;
    for (int k = 0; k < 2*NP; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (addr_ack == '0 && n < 20);
      chk("rr_ack_seen", addr_ack != '0, 1);
      for (int i = 0; i < NP; i++) if (addr_ack[i]) g = i;
      @(posedge clk); #1; rq_cyc[g] = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (k < 2*NP - 1) rq_cyc[g] = 1;
      else begin rq_cyc = '0; rd_rq = '0; fmc_select = '0; end
    end
    @(posedge clk); #1;
    chk("rr_idle", busy, 0);
    av_write(5, 36'h123456789);
    xact(0, 5, 1, 0, 0, '0, 0, 0, 0);
    xact(2, 3, 0, 1, 1, 36'hFFFFFFFFF, 4, 5, 0);
    av_read(3);
    rq_cyc[3] = 1; fmc_select[3] = 1; sel[15:12] = 4'h5; rd_rq[3] = 1;
    xact(1, 7, 1, 1, 1, 36'h5, 3, 1, 0);
    rq_cyc[3] = 0; fmc_select[3] = 0; sel[15:12] = 4'h0; rd_rq[3] = 0;
    av_read(7);
    wr_rs[1] = 1; mb_in[DW +: DW] = 36'hBADBADBAD;
    xact(0, 9, 0, 1, 0, '0, 0, 2, 0);
    wr_rs[1] = 0;
    av_read(9);
    for (int it = 0; it < 16; it++) begin
      p = $urandom_range(0, NP - 1);
      t = $urandom_range(0, 2);
      r = {$urandom(), $urandom()};
      n = $urandom_range(0, 15);
      xact(p, n, t != 1, t != 0, 1, r[DW-1:0], (t != 1) ? $urandom_range(2, 5) : $urandom_range(1, 4),
           $urandom_range(0, 2), 0);
      if (it % 4 == 3) av_read(AW'(n));
    end
    sw_single_step = 1;
    xact(0, 2, 1, 0, 0, '0, 0, 0, 0);
    chk("ss_stopped", stopped, 1);
    xact(1, 4, 1, 0, 0, '0, 0, 0, 1);
    chk("ss_cleared", stopped, 0);
    expect_ev(0, 0, '0);
    rq_cyc[0] = 1; fmc_select[0] = 1; ma[AW-1:0] = 4'd5; rd_rq[0] = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!addr_ack[0] && n < 20);
    chk("mid_ack", addr_ack[0], 1);
    @(posedge clk); #1;
    chk("mid_rd_rs", rd_rs[0], 1);
    reset_n = 0; #1;
    chk("mid_rst_rd_rs", rd_rs, 0);
    chk("mid_rst_mb_out", mb_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", addr_ack, 0);
    rq_cyc = '0; fmc_select = '0; rd_rq = '0; mlast = NP - 1;
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    av_read(5);
    xact(1, 6, 1, 0, 0, '0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
